cpu_trace_buffer: RTL and testbench

Parametrised, synthesizable execution-trace recorder for the 16-bit-instruction / 8-bit-datapath CPU; it supersedes per-cycle printing of PC, instruction and register state from the bench. It sits beside `cpu_struct` and is fed by a retire strobe carrying PC, instruction and the register-file writeback. Retired instructions are captured into a circular buffer with a PC-match trigger and a post-trigger window. The frozen history is then read back through a one-cycle-latency port, usable both in simulation and on hardware.

---
 rtl/cpu_dbg_pkg.sv | 33 +++
 rtl/trace_ram.sv | 44 ++++
 rtl/cpu_trace_buffer.sv | 188 ++++++++++++++++++
 tb/tb_cpu_trace_buffer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_dbg_pkg.sv
// rtl/cpu_dbg_pkg.sv - shared trace-buffer state encoding and entry field layout
//
// Purpose: state encoding for cpu_trace_buffer and the bit layout of a packed
// trace entry {pc, instr, wr_en, wr_addr, wr_data} for the default CPU widths,
// so that anything unpacking rd_data agrees with the packer.
package cpu_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_POST   = 2'd2,
    ST_FROZEN = 2'd3
  } trc_state_e;

  localparam int DEF_PC_W    = 8;
  localparam int DEF_INSTR_W = 16;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_NREGS   = 8;
  localparam int DEF_RA_W    = $clog2(DEF_NREGS);

  // Field offsets, LSB first: wr_data at bit 0, pc in the top bits.
  localparam int OFF_WR_DATA = 0;
  localparam int OFF_WR_ADDR = OFF_WR_DATA + DEF_DATA_W;
  localparam int OFF_WR_EN   = OFF_WR_ADDR + DEF_RA_W;
  localparam int OFF_INSTR   = OFF_WR_EN + 1;
  localparam int OFF_PC      = OFF_INSTR + DEF_INSTR_W;
  localparam int DEF_ENTRY_W = OFF_PC + DEF_PC_W;

  function automatic logic [DEF_PC_W-1:0] entry_pc(input logic [DEF_ENTRY_W-1:0] e);
    return e[OFF_PC +: DEF_PC_W];
  endfunction

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - simple dual-port trace storage with registered read port
//
// Purpose: DEPTH x WIDTH array, one write port and one read port whose data
// appears the cycle after rd_en and holds until the next rd_en.
// Ports:
//   clk      - clock
//   wr_en    - write strobe; wr_addr/wr_data written at the edge
//   rd_en    - read strobe; rd_data updated from rd_addr at the edge
//   rd_data  - registered read data (not reset; storage is never cleared)
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 33,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] rd_data_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/cpu_trace_buffer.sv
// rtl/cpu_trace_buffer.sv - circular retire-trace recorder with PC trigger and post window
//
// Purpose: captures retired instructions into a circular buffer while ARMED,
// fires on a PC match, records POST_CNT more entries, then freezes the history
// for readback through a one-cycle-latency port.
// Ports:
//   clk, reset          - clock, synchronous active-low reset
//   arm, stop           - control pulses (arm clears and starts, stop freezes)
//   trig_en, trig_pc    - PC-match trigger
//   cap_*               - retire strobe with PC, instruction and writeback
//   rd_req, rd_addr     - read request by logical index (0 = oldest)
//   rd_valid, rd_data   - read response, one cycle after rd_req
//   state, count, wrapped, triggered, trig_idx - status
module cpu_trace_buffer
  import cpu_dbg_pkg::*;
#(
  parameter int PC_W     = DEF_PC_W,
  parameter int INSTR_W  = DEF_INSTR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NREGS    = DEF_NREGS,
  parameter int DEPTH    = 16,
  parameter int POST_CNT = 4,
  localparam int RA_W    = $clog2(NREGS),
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int ENTRY_W = PC_W + INSTR_W + 1 + RA_W + DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arm,
  input  logic               stop,
  input  logic               trig_en,
  input  logic [PC_W-1:0]    trig_pc,
  input  logic               cap_valid,
  input  logic [PC_W-1:0]    cap_pc,
  input  logic [INSTR_W-1:0] cap_instr,
  input  logic               cap_wr_en,
  input  logic [RA_W-1:0]    cap_wr_addr,
  input  logic [DATA_W-1:0]  cap_wr_data,
  input  logic               rd_req,
  input  logic [PTR_W-1:0]   rd_addr,
  output logic               rd_valid,
  output logic [ENTRY_W-1:0] rd_data,
  output logic [1:0]         state,
  output logic [PTR_W:0]     count,
  output logic               wrapped,
  output logic               triggered,
  output logic [PTR_W-1:0]   trig_idx
);

  localparam int CNT_W = PTR_W + 1;

  trc_state_e       state_q,     state_d;
  logic [PTR_W-1:0] wr_ptr_q,    wr_ptr_d;
  logic [CNT_W-1:0] count_q,     count_d;
  logic [PTR_W-1:0] post_q,      post_d;
  logic [PTR_W-1:0] trig_slot_q, trig_slot_d;
  logic             wrapped_q,   wrapped_d;
  logic             triggered_q, triggered_d;
  logic             rd_valid_q,  rd_valid_d;
  // Out-of-range reads (and reset) force rd_data to zero without touching the RAM.
  logic             rd_zero_q,   rd_zero_d;

  logic               capturing;
  logic               cap_take;
  logic               trig_hit;
  logic               rd_ok;
  logic [PTR_W-1:0]   oldest;
  logic               ram_we;
  logic [PTR_W-1:0]   ram_rd_addr;
  logic [ENTRY_W-1:0] ram_wdata;
  logic [ENTRY_W-1:0] ram_rdata;

  assign oldest    = wrapped_q ? wr_ptr_q : '0;
  assign ram_wdata = {cap_pc, cap_instr, cap_wr_en, cap_wr_addr, cap_wr_data};

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    post_d      = post_q;
    trig_slot_d = trig_slot_q;
    wrapped_d   = wrapped_q;
    triggered_d = triggered_q;
    rd_valid_d  = 1'b0;
    rd_zero_d   = rd_zero_q;
    ram_we      = 1'b0;

    capturing = (state_q == ST_ARMED) || (state_q == ST_POST);
    cap_take  = cap_valid && capturing && !arm;
    trig_hit  = (state_q == ST_ARMED) && trig_en && (cap_pc == trig_pc);

    // Reads only see a stable buffer, and arm wins over a same-cycle read.
    rd_ok       = rd_req && !arm && ((state_q == ST_IDLE) || (state_q == ST_FROZEN));
    ram_rd_addr = oldest + rd_addr;
    if (rd_ok) begin
      rd_valid_d = 1'b1;
      rd_zero_d  = ({1'b0, rd_addr} >= count_q);
    end

    if (arm) begin
      state_d     = ST_ARMED;
      wr_ptr_d    = '0;
      count_d     = '0;
      post_d      = '0;
      trig_slot_d = '0;
      wrapped_d   = 1'b0;
      triggered_d = 1'b0;
    end else begin
      if (cap_take) begin
        ram_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (count_q == CNT_W'(DEPTH)) begin
          wrapped_d = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
        end

        if (trig_hit) begin
          triggered_d = 1'b1;
          trig_slot_d = wr_ptr_q;
          if (POST_CNT == 0) begin
            state_d = ST_FROZEN;
          end else begin
            state_d = ST_POST;
            post_d  = PTR_W'(POST_CNT);
          end
        end else if (state_q == ST_POST) begin
          post_d = post_q - PTR_W'(1);
          if (post_q == PTR_W'(1)) begin
            state_d = ST_FROZEN;
          end
        end
      end

      // The capture above is still stored when stop arrives in the same cycle.
      if (stop && capturing) begin
        state_d = ST_FROZEN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      post_q      <= '0;
      trig_slot_q <= '0;
      wrapped_q   <= 1'b0;
      triggered_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_zero_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      post_q      <= post_d;
      trig_slot_q <= trig_slot_d;
      wrapped_q   <= wrapped_d;
      triggered_q <= triggered_d;
      rd_valid_q  <= rd_valid_d;
      rd_zero_q   <= rd_zero_d;
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (wr_ptr_q),
    .wr_data (ram_wdata),
    .rd_en   (rd_ok),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_rdata)
  );

  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_zero_q ? '0 : ram_rdata;
  assign state     = state_q;
  assign count     = count_q;
  assign wrapped   = wrapped_q;
  assign triggered = triggered_q;
  // The trigger slot is never overwritten, so its distance from the oldest slot is its logical index.
  assign trig_idx  = triggered_q ? (trig_slot_q - oldest) : '0;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb/tb_cpu_trace_buffer.sv - self-checking bench for cpu_trace_buffer
module tb_cpu_trace_buffer;
  import cpu_dbg_pkg::*;

  localparam int PC_W    = DEF_PC_W;
  localparam int INSTR_W = DEF_INSTR_W;
  localparam int DATA_W  = DEF_DATA_W;
  localparam int RA_W    = DEF_RA_W;
  localparam int DEPTH   = 16;
  localparam int PTR_W   = 4;
  localparam int POST    = 4;
  localparam int EW      = DEF_ENTRY_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset = 1'b0, arm = 1'b0, stop = 1'b0, trig_en = 1'b0;
  logic [PC_W-1:0]    trig_pc = '0, cap_pc = '0;
  logic               cap_valid = 1'b0, cap_wr_en = 1'b0, rd_req = 1'b0;
  logic [INSTR_W-1:0] cap_instr = '0;
  logic [RA_W-1:0]    cap_wr_addr = '0;
  logic [DATA_W-1:0]  cap_wr_data = '0;
  logic [PTR_W-1:0]   rd_addr = '0;

  logic             rd_valid, rd_valid0;
  logic [EW-1:0]    rd_data, rd_data0;
  logic [1:0]       state, state0;
  logic [PTR_W:0]   count, count0;
  logic             wrapped, wrapped0, triggered, triggered0;
  logic [PTR_W-1:0] trig_idx, trig_idx0;

  cpu_trace_buffer #(.DEPTH(DEPTH), .POST_CNT(POST)) dut (
    .clk(clk), .reset(reset), .arm(arm), .stop(stop), .trig_en(trig_en), .trig_pc(trig_pc),
    .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_instr(cap_instr), .cap_wr_en(cap_wr_en),
    .cap_wr_addr(cap_wr_addr), .cap_wr_data(cap_wr_data), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .state(state), .count(count), .wrapped(wrapped),
    .triggered(triggered), .trig_idx(trig_idx));

  cpu_trace_buffer #(.DEPTH(DEPTH), .POST_CNT(0)) dut0 (
    .clk(clk), .reset(reset), .arm(arm), .stop(stop), .trig_en(trig_en), .trig_pc(trig_pc),
    .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_instr(cap_instr), .cap_wr_en(cap_wr_en),
    .cap_wr_addr(cap_wr_addr), .cap_wr_data(cap_wr_data), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_valid(rd_valid0), .rd_data(rd_data0), .state(state0), .count(count0), .wrapped(wrapped0),
    .triggered(triggered0), .trig_idx(trig_idx0));

  int checks = 0;
  int errors = 0;

  // Reference model of the POST_CNT=4 instance: history as an ordered queue.
  logic [EW-1:0] hist[$];
  trc_state_e    m_state = ST_IDLE;
  logic          m_wrapped = 1'b0, m_trig = 1'b0, m_rd_valid = 1'b0;
  logic [EW-1:0] m_rd_data = '0;
  int            m_trig_after = 0;
  int            m_post = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [EW-1:0] e;
    if (!reset) begin
      m_state = ST_IDLE; hist.delete(); m_wrapped = 0; m_trig = 0;
      m_trig_after = 0; m_post = 0; m_rd_valid = 0; m_rd_data = '0;
      return;
    end
    if (rd_req && !arm && (m_state == ST_IDLE || m_state == ST_FROZEN)) begin
      m_rd_valid = 1;
      m_rd_data  = (int'(rd_addr) < hist.size()) ? hist[rd_addr] : '0;
    end else begin
      m_rd_valid = 0;
    end
    if (arm) begin
      hist.delete(); m_wrapped = 0; m_trig = 0; m_trig_after = 0; m_post = 0;
      m_state = ST_ARMED;
      return;
    end
    if (m_state == ST_ARMED || m_state == ST_POST) begin
      if (cap_valid) begin
        e = {cap_pc, cap_instr, cap_wr_en, cap_wr_addr, cap_wr_data};
        if (hist.size() == DEPTH) begin
          void'(hist.pop_front());
          m_wrapped = 1;
        end
        hist.push_back(e);
        if (m_trig) m_trig_after++;
        if (m_state == ST_ARMED && trig_en && cap_pc == trig_pc) begin
          m_trig = 1; m_trig_after = 0;
          m_state = ST_POST; m_post = POST;
        end else if (m_state == ST_POST) begin
          m_post--;
          if (m_post == 0) m_state = ST_FROZEN;
        end
      end
      if (stop) m_state = ST_FROZEN;
    end
  endtask

  task automatic check_all();
    chk("state", 64'(state), 64'(m_state));
    chk("count", 64'(count), 64'(hist.size()));
    chk("wrapped", 64'(wrapped), 64'(m_wrapped));
    chk("triggered", 64'(triggered), 64'(m_trig));
    chk("rd_valid", 64'(rd_valid), 64'(m_rd_valid));
    chk("rd_data", 64'(rd_data), 64'(m_rd_data));
    if (m_state == ST_FROZEN && m_trig)
      chk("trig_idx", 64'(trig_idx), 64'(hist.size() - 1 - m_trig_after));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    arm = 0; stop = 0; cap_valid = 0; rd_req = 0; reset = 1;
  endtask

  task automatic cap(input int pc);
    cap_valid = 1; cap_pc = PC_W'(pc);
    cap_instr = INSTR_W'($urandom); cap_wr_en = 1'($urandom);
    cap_wr_addr = RA_W'($urandom); cap_wr_data = DATA_W'($urandom);
    tick();
  endtask

  task automatic rd(input int a);
    rd_req = 1; rd_addr = PTR_W'(a);
    tick();
  endtask

  initial begin
    // Reset state
    reset = 0; tick();
    chk("rst_state", 64'(state), 64'(ST_IDLE));
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_trig_idx", 64'(trig_idx), 64'd0);
    cap(1); cap(2);
    chk("idle_ignores", 64'(count), 64'd0);

    // Fill without wrap
    arm = 1; tick();
    for (int i = 0; i < 5; i++) cap(i);
    stop = 1; tick();
    chk("fill_state", 64'(state), 64'(ST_FROZEN));
    chk("fill_count", 64'(count), 64'd5);
    chk("fill_wrapped", 64'(wrapped), 64'd0);
    rd(2);
    chk("fill_rd_valid", 64'(rd_valid), 64'd1);
    chk("fill_pc2", 64'(entry_pc(rd_data)), 64'd2);
    rd(7);
    chk("oob_rd_valid", 64'(rd_valid), 64'd1);
    chk("oob_rd_data", 64'(rd_data), 64'd0);

    // Wrap
    arm = 1; tick();
    for (int i = 0; i < 20; i++) cap(i);
    stop = 1; tick();
    chk("wrap_count", 64'(count), 64'd16);
    chk("wrap_flag", 64'(wrapped), 64'd1);
    rd(0);  chk("wrap_pc_old", 64'(entry_pc(rd_data)), 64'd4);
    rd(15); chk("wrap_pc_new", 64'(entry_pc(rd_data)), 64'd19);

    // Trigger with post window (dut0 freezes on the trigger itself)
    trig_en = 1; trig_pc = 8'd10;
    arm = 1; tick();
    for (int i = 0; i <= 30; i++) cap(i);
    chk("trg_state", 64'(state), 64'(ST_FROZEN));
    chk("trg_count", 64'(count), 64'd15);
    chk("trg_flag", 64'(triggered), 64'd1);
    chk("trg_idx", 64'(trig_idx), 64'd10);
    rd(10); chk("trg_pc", 64'(entry_pc(rd_data)), 64'd10);
    rd(14); chk("trg_last_pc", 64'(entry_pc(rd_data)), 64'd14);
    chk("trg0_count", 64'(count0), 64'd11);

    // Zero-length post window on dut0
    trig_pc = 8'd3;
    arm = 1; tick();
    for (int i = 0; i < 6; i++) cap(i);
    chk("p0_state", 64'(state0), 64'(ST_FROZEN));
    chk("p0_count", 64'(count0), 64'd4);
    chk("p0_trig_idx", 64'(trig_idx0), 64'd3);
    rd(3);
    chk("p0_pc", 64'(entry_pc(rd_data0)), 64'd3);
    chk("p0_rd_valid", 64'(rd_valid0), 64'd1);
    chk("post_state", 64'(state), 64'(ST_POST));

    // Reset in POST with a read request
    rd_req = 1; rd_addr = 4'd1; reset = 0; tick();
    chk("rstp_state", 64'(state), 64'(ST_IDLE));
    chk("rstp_count", 64'(count), 64'd0);
    chk("rstp_rd_valid", 64'(rd_valid), 64'd0);
    chk("rstp_trig", 64'(triggered), 64'd0);

    // Collisions
    arm = 1; cap_valid = 1; cap_pc = 8'd50; tick();
    chk("armcap_count", 64'(count), 64'd0);
    cap(51);
    rd(0); chk("armed_rd_valid", 64'(rd_valid), 64'd0);

    // Randomised traffic against the model
    for (int n = 0; n < 800; n++) begin
      arm       = ($urandom_range(0, 39) == 0);
      stop      = ($urandom_range(0, 59) == 0);
      rd_req    = ($urandom_range(0, 3) == 0);
      rd_addr   = PTR_W'($urandom);
      trig_en   = 1'($urandom);
      if ($urandom_range(0, 29) == 0) trig_pc = PC_W'($urandom_range(0, 31));
      reset     = ($urandom_range(0, 199) != 0);
      cap_valid = 1'($urandom);
      cap_pc    = PC_W'($urandom_range(0, 31));
      cap_instr = INSTR_W'($urandom); cap_wr_en = 1'($urandom);
      cap_wr_addr = RA_W'($urandom); cap_wr_data = DATA_W'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
